// File: rtl/control_sequencer.sv
// control_sequencer
//   Fetch/decode/execute sequencer for the 8-bit bus processor. It drives the
//   bus-drive and load strobes of the PC, IR, MAR, MDR, accumulator/ALU and
//   memory. Most states are Moore. DECODE is Mealy on op/z_flag, and EXEC is
//   Mealy on op so the correct ALU operation is selected.
// Ports
//   clock, n_reset        : system clock, async active-low reset
//   op[OP_W-1:0]          : opcode from IR (valid from DECODE onward)
//   z_flag                : accumulator zero flag (BNE condition)
//   mem_ready             : memory finishes the current access this cycle
//   PC_bus/load_PC/INC_PC : PC drive, load, increment select
//   load_IR, Addr_bus     : IR load, IR address field drive
//   load_MAR              : MAR load
//   MDR_bus/load_MDR      : MDR drive, load
//   ACC_bus/load_ACC      : accumulator drive, load
//   ALU_ACC/ALU_add/ALU_sub : ALU result into acc, add, subtract
//   CS, R_NW              : memory select, read(1)/write(0)
//   halted                : processor stopped
module control_sequencer #(
  parameter int OP_W = 3
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            mem_ready,
  output logic            PC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_IR,
  output logic            Addr_bus,
  output logic            load_MAR,
  output logic            MDR_bus,
  output logic            load_MDR,
  output logic            ACC_bus,
  output logic            load_ACC,
  output logic            ALU_ACC,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            CS,
  output logic            R_NW,
  output logic            halted
);

  // Any opcode value not listed here falls through to NOP. This includes
  // the upper codes when OP_W > 3, so a stray value can never halt the CPU.
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_READ, S_EXEC, S_WRDATA, S_WRITE, S_HALT
  } state_t;

  state_t state;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state <= S_FETCH0;
        S_FETCH0: state <= S_FETCH1;
        S_FETCH1: if (mem_ready) state <= S_FETCH2;
        S_FETCH2: state <= S_DECODE;
        S_DECODE: begin
          if (op == OP_LOAD || op == OP_ADD || op == OP_SUB) state <= S_READ;
          else if (op == OP_STORE)                           state <= S_WRDATA;
          else if (op == OP_HALT)                            state <= S_HALT;
          else                                               state <= S_FETCH0;
        end
        S_READ:   if (mem_ready) state <= S_EXEC;
        S_EXEC:   state <= S_FETCH0;
        S_WRDATA: state <= S_WRITE;
        S_WRITE:  if (mem_ready) state <= S_FETCH0;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // The strobes are decoded from the state register without any output
  // flops. This lets the async reset clear every strobe at once, and it
  // lets the DECODE and EXEC strobes follow op/z_flag within the same cycle.
  always_comb begin
    PC_bus   = 1'b0;
    load_PC  = 1'b0;
    INC_PC   = 1'b0;
    load_IR  = 1'b0;
    Addr_bus = 1'b0;
    load_MAR = 1'b0;
    MDR_bus  = 1'b0;
    load_MDR = 1'b0;
    ACC_bus  = 1'b0;
    load_ACC = 1'b0;
    ALU_ACC  = 1'b0;
    ALU_add  = 1'b0;
    ALU_sub  = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH0: begin
        PC_bus   = 1'b1;
        load_MAR = 1'b1;
        load_PC  = 1'b1;
        INC_PC   = 1'b1;
      end
      S_FETCH1, S_READ: begin
        CS   = 1'b1;
        R_NW = 1'b1;
      end
      S_FETCH2: begin
        MDR_bus = 1'b1;
        load_IR = 1'b1;
      end
      S_DECODE: begin
        if (op == OP_LOAD || op == OP_ADD || op == OP_SUB || op == OP_STORE) begin
          Addr_bus = 1'b1;
          load_MAR = 1'b1;
        end else if (op == OP_BNE && !z_flag) begin
          // INC_PC stays low, so the PC takes the address field
          Addr_bus = 1'b1;
          load_PC  = 1'b1;
        end
      end
      S_EXEC: begin
        MDR_bus  = 1'b1;
        load_ACC = 1'b1;
        if (op == OP_ADD) begin
          ALU_ACC = 1'b1;
          ALU_add = 1'b1;
        end else if (op == OP_SUB) begin
          ALU_ACC = 1'b1;
          ALU_sub = 1'b1;
        end
      end
      S_WRDATA: begin
        ACC_bus  = 1'b1;
        load_MDR = 1'b1;
      end
      S_WRITE:  CS     = 1'b1;
      S_HALT:   halted = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
  logic       clock = 1'b0;
  logic       n_reset;
  logic [2:0] op;
  logic       z_flag;
  logic       mem_ready;
  logic PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR, MDR_bus, load_MDR;
  logic ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, CS, R_NW, halted;

  int tests = 0;
  int fails = 0;
  int excl_viol = 0;

  control_sequencer #(.OP_W(3)) dut (
    .clock(clock), .n_reset(n_reset), .op(op), .z_flag(z_flag),
    .mem_ready(mem_ready), .PC_bus(PC_bus), .load_PC(load_PC), .INC_PC(INC_PC),
    .load_IR(load_IR), .Addr_bus(Addr_bus), .load_MAR(load_MAR),
    .MDR_bus(MDR_bus), .load_MDR(load_MDR), .ACC_bus(ACC_bus),
    .load_ACC(load_ACC), .ALU_ACC(ALU_ACC), .ALU_add(ALU_add),
    .ALU_sub(ALU_sub), .CS(CS), .R_NW(R_NW), .halted(halted)
  );

  always #5 clock = ~clock;

  // {PC_bus,load_PC,INC_PC,load_IR,Addr_bus,load_MAR,MDR_bus,load_MDR,
  //  ACC_bus,load_ACC,ALU_ACC,ALU_add,ALU_sub,CS,R_NW,halted}
  logic [15:0] outv;
  assign outv = {PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR, MDR_bus,
                 load_MDR, ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, CS,
                 R_NW, halted};

  localparam logic [15:0] O_IDLE = 16'h0000;
  localparam logic [15:0] O_F0   = 16'hE400;
  localparam logic [15:0] O_F1   = 16'h0006;
  localparam logic [15:0] O_F2   = 16'h1200;
  localparam logic [15:0] O_DMEM = 16'h0C00;
  localparam logic [15:0] O_DBR  = 16'h4800;
  localparam logic [15:0] O_RD   = 16'h0006;
  localparam logic [15:0] O_XLD  = 16'h0240;
  localparam logic [15:0] O_XADD = 16'h0270;
  localparam logic [15:0] O_XSUB = 16'h0268;
  localparam logic [15:0] O_WRD  = 16'h0180;
  localparam logic [15:0] O_WR   = 16'h0004;
  localparam logic [15:0] O_HALT = 16'h0001;

  // bus exclusivity and load_PC/load_IR exclusion, every cycle
  always @(negedge clock)
    if (n_reset === 1'b1 &&
        (($countones({PC_bus, Addr_bus, MDR_bus, ACC_bus}) > 1) ||
         (load_PC && load_IR)))
      excl_viol++;

  // stimulus only: reset pulse spanning one edge, ends at a negedge in IDLE
  task automatic pulse_reset();
    @(negedge clock);
    n_reset = 1'b0;
    @(negedge clock);
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; op = 3'd0; z_flag = 1'b0; mem_ready = 1'b1;
    #12;
    tests++;
    if (outv !== O_IDLE) begin
      fails++;
      $display("FAIL reset_outputs got=%h exp=%h", outv, O_IDLE);
    end
    @(negedge clock);
    n_reset = 1'b1;
  endtask

  task automatic test_load();
    logic [15:0] exp[$] = '{O_IDLE, O_F0, O_F1, O_F2, O_DMEM, O_RD, O_XLD, O_F0};
    op = 3'd0; z_flag = 1'b0; mem_ready = 1'b1;
    pulse_reset();
    foreach (exp[i]) begin
      tests++;
      if (outv !== exp[i]) begin
        fails++;
        $display("FAIL load cyc%0d got=%h exp=%h", i, outv, exp[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_add_wait();
    logic [15:0] exp[$] = '{O_IDLE, O_F0, O_F1, O_F2, O_DMEM, O_RD, O_RD, O_RD,
                            O_RD, O_XADD, O_F0};
    bit rdy[$] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    op = 3'd2; z_flag = 1'b1;
    mem_ready = 1'b1;
    pulse_reset();
    foreach (exp[i]) begin
      mem_ready = rdy[i];
      tests++;
      if (outv !== exp[i]) begin
        fails++;
        $display("FAIL add_wait cyc%0d got=%h exp=%h", i, outv, exp[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_sub_fetch_wait();
    // two wait cycles in FETCH1, then SUB
    logic [15:0] exp[$] = '{O_IDLE, O_F0, O_F1, O_F1, O_F1, O_F2, O_DMEM, O_RD,
                            O_XSUB, O_F0};
    bit rdy[$] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    op = 3'd3; z_flag = 1'b0;
    mem_ready = 1'b1;
    pulse_reset();
    foreach (exp[i]) begin
      mem_ready = rdy[i];
      tests++;
      if (outv !== exp[i]) begin
        fails++;
        $display("FAIL sub_fwait cyc%0d got=%h exp=%h", i, outv, exp[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_store();
    logic [15:0] exp0[$] = '{O_IDLE, O_F0, O_F1, O_F2, O_DMEM, O_WRD, O_WR, O_F0};
    logic [15:0] exp2[$] = '{O_IDLE, O_F0, O_F1, O_F2, O_DMEM, O_WRD, O_WR, O_WR,
                             O_WR, O_F0};
    bit rdy2[$] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    op = 3'd1; z_flag = 1'b0; mem_ready = 1'b1;
    pulse_reset();
    foreach (exp0[i]) begin
      tests++;
      if (outv !== exp0[i]) begin
        fails++;
        $display("FAIL store0 cyc%0d got=%h exp=%h", i, outv, exp0[i]);
      end
      @(negedge clock);
    end
    pulse_reset();
    foreach (exp2[i]) begin
      mem_ready = rdy2[i];
      tests++;
      if (outv !== exp2[i]) begin
        fails++;
        $display("FAIL store2 cyc%0d got=%h exp=%h", i, outv, exp2[i]);
      end
      @(negedge clock);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_branch_nop();
    // {op, z_flag, expected DECODE outputs}
    logic [2:0]  ops[4] = '{3'd4, 3'd4, 3'd5, 3'd6};
    logic        zs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] dx[4]  = '{O_DBR, O_IDLE, O_IDLE, O_IDLE};
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] exp[$];
      exp = '{O_IDLE, O_F0, O_F1, O_F2, dx[k], O_F0, O_F1};
      op = ops[k]; z_flag = zs[k];
      pulse_reset();
      foreach (exp[i]) begin
        tests++;
        if (outv !== exp[i]) begin
          fails++;
          $display("FAIL br_nop op=%0d z=%0d cyc%0d got=%h exp=%h",
                   ops[k], zs[k], i, outv, exp[i]);
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_halt();
    logic [15:0] exp[$] = '{O_IDLE, O_F0, O_F1, O_F2, O_IDLE, O_HALT};
    op = 3'd7; z_flag = 1'b0; mem_ready = 1'b1;
    pulse_reset();
    foreach (exp[i]) begin
      tests++;
      if (outv !== exp[i]) begin
        fails++;
        $display("FAIL halt_entry cyc%0d got=%h exp=%h", i, outv, exp[i]);
      end
      @(negedge clock);
    end
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(0, 7));
      mem_ready = 1'($urandom_range(0, 1));
      z_flag = 1'($urandom_range(0, 1));
      @(negedge clock);
      tests++;
      if (outv !== O_HALT) begin
        fails++;
        $display("FAIL halt_stay cyc%0d got=%h exp=%h", i, outv, O_HALT);
      end
    end
    mem_ready = 1'b1;
    pulse_reset();
    tests++;
    if (outv !== O_IDLE) begin
      fails++;
      $display("FAIL halt_reset got=%h exp=%h", outv, O_IDLE);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] exp[$] = '{O_IDLE, O_F0, O_F1, O_F2, O_DMEM};
    op = 3'd0; z_flag = 1'b0; mem_ready = 1'b1;
    pulse_reset();
    @(negedge clock);   // FETCH0
    mem_ready = 1'b0;
    @(negedge clock);   // FETCH1 waiting
    @(negedge clock);   // still FETCH1
    tests++;
    if (outv !== O_F1) begin
      fails++;
      $display("FAIL fetch1_wait got=%h exp=%h", outv, O_F1);
    end
    #2 n_reset = 1'b0;  // between edges
    #1;
    tests++;
    if (outv !== O_IDLE) begin
      fails++;
      $display("FAIL async_reset got=%h exp=%h", outv, O_IDLE);
    end
    mem_ready = 1'b1;
    @(negedge clock);
    tests++;
    if (outv !== O_IDLE) begin
      fails++;
      $display("FAIL async_hold got=%h exp=%h", outv, O_IDLE);
    end
    n_reset = 1'b1;
    foreach (exp[i]) begin
      tests++;
      if (outv !== exp[i]) begin
        fails++;
        $display("FAIL restart cyc%0d got=%h exp=%h", i, outv, exp[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_exclusive();
    tests++;
    if (excl_viol !== 0) begin
      fails++;
      $display("FAIL bus_exclusive got=%0d exp=0", excl_viol);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_add_wait();
    test_sub_fetch_wait();
    test_store();
    test_branch_nop();
    test_halt();
    test_async_reset();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Moore/Mealy control state machine for the basic 8-bit bus processor. It sits upstream of the program counter, instruction register, accumulator/ALU, MAR/MDR and memory, and sequences their bus-drive and load strobes. Each instruction runs through fetch, decode and execute on the shared `sysbus`. The sequencer issues the `PC_bus`, `load_PC` and `INC_PC` controls that the PC consumes. It handshakes with memory through a `mem_ready` wait input.

## Interface
- `OP_W`, default 3: opcode width; the opcode field is the upper `OP_W` bits of the instruction word.
- `clock` input, 1 bit: single system clock; all state changes occur on the rising edge.
- `n_reset` input, 1 bit: asynchronous, active-low reset.
- `op` input, `OP_W` bits: opcode from the IR. It is valid from the DECODE state onward.
- `z_flag` input, 1 bit: accumulator-zero flag.
- `mem_ready` input, 1 bit: memory completes the current access in this cycle.
- `PC_bus`, `load_PC`, `INC_PC` output, 1 bit each: PC drives the bus, PC load enable, and increment select.
- `load_IR` output, 1 bit: IR loads from `sysbus`.
- `Addr_bus` output, 1 bit: IR address field drives `sysbus`.
- `load_MAR` output, 1 bit: MAR load enable.
- `MDR_bus`, `load_MDR` output, 1 bit each: MDR drives the bus; MDR load enable.
- `ACC_bus`, `load_ACC` output, 1 bit each: accumulator drives the bus; accumulator load enable.
- `ALU_ACC`, `ALU_add`, `ALU_sub` output, 1 bit each: ALU result selected into the accumulator; add operation; subtract operation.
- `CS`, `R_NW` output, 1 bit each: memory chip select; read (1) or write (0).
- `halted` output, 1 bit: processor is stopped.

## Operation
- Opcodes:
  - 000 LOAD
  - 001 STORE
  - 010 ADD
  - 011 SUB
  - 100 BNE: branch to the address field if `z_flag`=0
  - 101 and 110: NOP
  - 111 HALT
- Every output not listed for a state is 0.
- States and transitions:
  - IDLE: no outputs asserted. Next state is FETCH0.
  - FETCH0: `PC_bus`, `load_MAR`, `load_PC`, `INC_PC` (PC increments). Next state is FETCH1.
  - FETCH1: `CS`, `R_NW`. Stays here while `mem_ready`=0; goes to FETCH2 when `mem_ready`=1.
  - FETCH2: `MDR_bus`, `load_IR`. Next state is DECODE.
  - DECODE: outputs and next state are Mealy on `op` and `z_flag`:
    - LOAD, ADD, SUB: `Addr_bus`, `load_MAR`. Next state is READ.
    - STORE: `Addr_bus`, `load_MAR`. Next state is WRDATA.
    - BNE with `z_flag`=0: `Addr_bus`, `load_PC` with `INC_PC`=0, so the PC loads the address. Next state is FETCH0.
    - BNE with `z_flag`=1: no outputs asserted. Next state is FETCH0.
    - NOP: no outputs asserted. Next state is FETCH0.
    - HALT: no outputs asserted. Next state is HALT.
  - READ: `CS`, `R_NW`. Waits on `mem_ready` as in FETCH1. Next state is EXEC.
  - EXEC: `MDR_bus`, `load_ACC`.
    - ADD additionally asserts `ALU_ACC` and `ALU_add`.
    - SUB additionally asserts `ALU_ACC` and `ALU_sub`.
    - LOAD asserts `ALU_ACC`=0, so the accumulator takes the bus value directly.
    - Next state is FETCH0.
  - WRDATA: `ACC_bus`, `load_MDR`. Next state is WRITE.
  - WRITE: `CS`, `R_NW`=0. Waits on `mem_ready`. Next state is FETCH0.
  - HALT: `halted`=1. Absorbing; only reset leaves this state.
- Bus exclusivity: at most one of `PC_bus`, `Addr_bus`, `MDR_bus`, `ACC_bus` is 1 in any state.
- `load_PC`=1 and `load_IR`=1 are never asserted in the same cycle.

## Timing
- `n_reset`=0 forces IDLE immediately, independent of the clock. All outputs are then 0, including `halted`.
  - Reset asserted mid-instruction or mid-wait abandons the instruction; no partial strobes follow.
- The first rising edge after `n_reset` rises moves IDLE to FETCH0.
- Cycle counts with zero wait states (`mem_ready` held at 1):
  - LOAD, ADD, SUB, STORE: 6 cycles (FETCH0 to the last execute state).
  - BNE, NOP: 4 cycles.
  - HALT: 4 cycles to reach HALT.
- Each cycle with `mem_ready`=0 in FETCH1, READ or WRITE adds exactly one cycle. `CS` and `R_NW` stay stable throughout the wait.
- DECODE outputs depend combinationally on `op` and `z_flag` sampled in that cycle.
- `op` and `z_flag` are ignored in every other state, except `op` during EXEC.
- An unknown or reserved opcode is treated as NOP, never as HALT.

## Test plan
- Reset then run with `op`=000 and `mem_ready`=1: the state sequence is IDLE, FETCH0, FETCH1, FETCH2, DECODE, READ, EXEC, FETCH0. EXEC shows `MDR_bus`=1, `load_ACC`=1, `ALU_ACC`=0.
- `op`=010 with `mem_ready` held at 0 for 3 cycles in READ: `CS`=1 and `R_NW`=1 for 4 cycles; EXEC shows `ALU_ACC`=1, `ALU_add`=1; total is 9 cycles.
- `op`=001: WRDATA shows `ACC_bus`=1, `load_MDR`=1; WRITE shows `CS`=1, `R_NW`=0. Check with 0 and with 2 wait cycles.
- `op`=100 with `z_flag`=0: DECODE shows `Addr_bus`=1, `load_PC`=1, `INC_PC`=0. Repeat with `z_flag`=1: DECODE shows all outputs 0. Both return to FETCH0 after 4 cycles.
- `op`=111: reaches HALT with `halted`=1 and stays there 20 cycles with all other outputs 0 regardless of `op` or `mem_ready`. Pulsing `n_reset` low returns to IDLE with `halted`=0.
- Assert `n_reset`=0 asynchronously mid-FETCH1 wait: outputs go to 0 before the next edge; the restart sequence begins at IDLE. A bus-exclusivity assertion checks every cycle.
